led_pattern_sequencer: RTL and testbench

Sequences the board LED bank through selectable patterns: all-off, blink-all, one-hot chase and binary count. A prescaler derives the pattern step rate from the 27 MHz board clock, and pause/single-step controls allow manual stepping. A PWM stage dims the bank before it drives the active-low LED pins. Replaces free-running per-design blink logic as the single owner of the LED outputs.

---
 rtl/led_pattern_sequencer_if.sv | 24 ++
 rtl/led_pattern_sequencer.sv | 96 +++++++++
 tb/tb_led_pattern_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Control and display signals of the LED pattern sequencer.
// master drives the controls and observes the LEDs; slave is the sequencer itself.
interface led_pattern_sequencer_if #(
    parameter int unsigned led_number = 6,
    parameter int unsigned PWM_BITS   = 4
);
    logic [1:0]            mode;
    logic                  pause;
    logic                  step;
    logic [PWM_BITS-1:0]   brightness;
    logic [led_number-1:0] leds;
    logic [led_number-1:0] pattern;
    logic                  tick;

    modport master (
        output mode, pause, step, brightness,
        input  leds, pattern, tick
    );

    modport slave (
        input  mode, pause, step, brightness,
        output leds, pattern, tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps the LED bank through off/blink/chase/count patterns at a prescaled rate,
// with pause/single-step control and PWM dimming onto active-low pins.
module led_pattern_sequencer #(
    parameter int unsigned led_number  = 6,
    parameter int unsigned TICK_CYCLES = 13500000,
    parameter int unsigned PWM_BITS    = 4
) (
    input logic                    clk,
    input logic                    rst,
    led_pattern_sequencer_if.slave bus
);
    localparam int unsigned PrescW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeBlink = 2'd1,
        ModeChase = 2'd2,
        ModeCount = 2'd3
    } mode_e;

    mode_e                 mode_in;
    mode_e                 mode_q, mode_d;
    logic [led_number-1:0] pattern_q, pattern_d;
    logic [PrescW-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  tick_q, tick_d;
    logic [led_number-1:0] leds_q, leds_d;

    logic mode_change;
    logic advance;
    logic pwm_on;

    assign mode_in = mode_e'(bus.mode);

    always_comb begin
        mode_change = (mode_in != mode_q);
        // step only counts while paused; auto-advance only while running
        advance     = (!bus.pause && (presc_q == PrescMax)) || (bus.pause && bus.step);
        pwm_on      = (bus.brightness == '1) || (pwm_cnt_q < bus.brightness);

        mode_d    = mode_q;
        pattern_d = pattern_q;
        tick_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        leds_d    = ~(pattern_q & {led_number{pwm_on}});

        if (bus.pause || (presc_q == PrescMax)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (mode_change) begin
            // a coincident advance is dropped in favour of the new mode's seed
            mode_d  = mode_in;
            presc_d = '0;
            unique case (mode_in)
                ModeOff:   pattern_d = '0;
                ModeBlink: pattern_d = '1;
                ModeChase: pattern_d = {{(led_number-1){1'b0}}, 1'b1};
                ModeCount: pattern_d = '0;
            endcase
        end else if (advance) begin
            tick_d = 1'b1;
            unique case (mode_q)
                ModeOff:   pattern_d = '0;
                ModeBlink: pattern_d = ~pattern_q;
                ModeChase: pattern_d = {pattern_q[led_number-2:0], pattern_q[led_number-1]};
                ModeCount: pattern_d = pattern_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= ModeOff;
            pattern_q <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
            leds_q    <= '1;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= tick_d;
            leds_q    <= leds_d;
        end
    end

    assign bus.pattern = pattern_q;
    assign bus.tick    = tick_q;
    assign bus.leds    = leds_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: driver feeds a spec-level model whose post-edge outputs are
// queued; a monitor compares them against the DUT one cycle at a time.
module tb_led_pattern_sequencer;
    localparam int unsigned N    = 6;
    localparam int unsigned TICK = 4;
    localparam int unsigned PB   = 4;
    localparam int          FULL = 1 << N;
    localparam int          PWMP = 1 << PB;

    typedef struct {
        logic [N-1:0] pat;
        logic         tick;
        logic [N-1:0] leds;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    exp_t exp_q[$];

    // reference model state
    int m_mode;
    int m_pat;
    int m_cnt;
    int m_phase;

    led_pattern_sequencer_if #(.led_number(N), .PWM_BITS(PB)) bus ();

    led_pattern_sequencer #(
        .led_number (N),
        .TICK_CYCLES(TICK),
        .PWM_BITS   (PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int seed_pat(input int md);
        case (md)
            1:       return FULL - 1;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int next_pat(input int md, input int p);
        case (md)
            1:       return (FULL - 1) - p;
            2:       return ((p * 2) % FULL) + ((p >= FULL / 2) ? 1 : 0);
            3:       return (p + 1) % FULL;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input int md, input bit ps, input bit st, input int br);
        exp_t e;
        bit   lit;
        bit   adv;
        if (r) begin
            m_mode  = 0;
            m_pat   = 0;
            m_cnt   = 0;
            m_phase = 0;
            e.tick  = 1'b0;
            e.leds  = N'(FULL - 1);
        end else begin
            lit     = (br == PWMP - 1) || (m_phase < br);
            e.leds  = lit ? N'((FULL - 1) - m_pat) : N'(FULL - 1);
            m_phase = (m_phase + 1) % PWMP;
            if (md != m_mode) begin
                m_mode = md;
                m_pat  = seed_pat(md);
                m_cnt  = 0;
                e.tick = 1'b0;
            end else begin
                adv    = ps ? st : (m_cnt == TICK - 1);
                m_cnt  = ps ? 0 : (m_cnt + 1) % TICK;
                e.tick = adv;
                if (adv) m_pat = next_pat(m_mode, m_pat);
            end
        end
        e.pat = N'(m_pat);
        exp_q.push_back(e);
    endtask

    // Inputs change 2 time units after the edge; the model predicts the next edge.
    task automatic drive(input bit r, input int md, input bit ps, input bit st, input int br);
        @(posedge clk);
        #2;
        rst            = r;
        bus.mode       = md[1:0];
        bus.pause      = ps;
        bus.step       = st;
        bus.brightness = br[PB-1:0];
        model_step(r, md, ps, st, br);
    endtask

    // Outputs here reflect the edge before the most recent drive() call.
    task automatic check_now(input string name, input int pat, input bit tk, input int ld);
        n_checks++;
        if (bus.pattern !== N'(pat) || bus.tick !== tk || bus.leds !== N'(ld)) begin
            n_fail++;
            $display("FAIL %s: got pattern=%h tick=%b leds=%h, want pattern=%h tick=%b leds=%h",
                     name, bus.pattern, bus.tick, bus.leds, N'(pat), tk, N'(ld));
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pattern !== e.pat || bus.tick !== e.tick || bus.leds !== e.leds) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got pattern=%h tick=%b leds=%h, want pattern=%h tick=%b leds=%h",
                         cyc, bus.pattern, bus.tick, bus.leds, e.pat, e.tick, e.leds);
            end
        end
    end

    initial begin
        int lit_cnt;
        int cur_mode;
        bit cur_pause;
        int cur_br;
        bit r;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst            = 1'b1;
        bus.mode       = 2'd0;
        bus.pause      = 1'b0;
        bus.step       = 1'b0;
        bus.brightness = '0;

        // Reset with random inputs, then idle in OFF
        for (int i = 0; i < 3; i++)
            drive(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 15));
        check_now("reset_values", 0, 0, FULL - 1);
        for (int i = 0; i < 50; i++)
            drive(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
        check_now("off_hold", 0, 0, FULL - 1);

        // CHASE wrap
        for (int i = 0; i < 30; i++) begin
            drive(0, 2, 0, 0, 15);
            if (i == 1)  check_now("chase_seed", 1, 0, FULL - 1);
            if (i == 5)  check_now("chase_tick1", 2, 1, 6'h3E);
            if (i == 25) check_now("chase_wrap", 1, 1, 6'h1F);
        end

        // COUNT wrap
        for (int i = 0; i < 260; i++) begin
            drive(0, 3, 0, 0, 15);
            if (i == 253) check_now("count_max", FULL - 1, 1, 6'h01);
            if (i == 257) check_now("count_wrap", 0, 1, 6'h00);
        end

        // Pause / single step in BLINK
        drive(0, 1, 0, 0, 15);
        for (int i = 0; i < 40; i++) drive(0, 1, 1, 0, 15);
        check_now("pause_frozen", FULL - 1, 0, 6'h00);
        drive(0, 1, 1, 1, 15);
        drive(0, 1, 1, 0, 15);
        check_now("single_step", 0, 1, 6'h00);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, 0, 15);
        drive(0, 1, 0, 1, 15);
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 15);

        // PWM duty on a full pattern
        drive(0, 0, 0, 0, 15);
        drive(0, 1, 1, 0, 4);
        drive(0, 1, 1, 0, 4);
        drive(0, 1, 1, 0, 4);
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 1, 0, 4);
            if (bus.leds[0] === 1'b0) lit_cnt++;
        end
        n_checks++;
        if (lit_cnt != 8) begin
            n_fail++;
            $display("FAIL pwm_duty4: lit cycles got %0d want 8", lit_cnt);
        end
        for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0);
        check_now("pwm_dark", FULL - 1, 0, FULL - 1);
        for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 15);
        check_now("pwm_full", FULL - 1, 0, 0);

        // Mode change colliding with a prescaler wrap, then mid-COUNT reset
        drive(0, 0, 0, 0, 15);
        drive(0, 1, 0, 0, 15);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 15);
        drive(0, 2, 0, 0, 15);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 2, 0, 0, 15);
            if (i == 1) check_now("collide_seed", 1, 0, 6'h00);
            if (i == 5) check_now("collide_next_tick", 2, 1, 6'h3E);
        end
        for (int i = 0; i < 20; i++) drive(0, 3, 0, 0, 15);
        drive(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), 15);
        drive(0, 0, 0, 0, 15);
        check_now("mid_reset", 0, 0, FULL - 1);

        // Randomized traffic
        cur_mode  = 0;
        cur_pause = 0;
        cur_br    = 15;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) cur_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) cur_pause = ~cur_pause;
            if ($urandom_range(0, 19) == 0) cur_br = $urandom_range(0, 15);
            drive(r, cur_mode, cur_pause, ($urandom_range(0, 4) == 0), cur_br);
        end

        drive(0, cur_mode, 1, 0, cur_br);
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queue holds %0d entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
